pump_sequencer: RTL and testbench
=================================

// Module: pump_sequencer
// PURPOSE
//  Parametrised multi-pump sump controller; next generation of the 3-sensor/2-pump micro controller.
//  Reads N_LEVELS thermometer-coded level sensors and stages N_PUMPS pumps.
//  Adds input sync/debounce, one-sensor hysteresis and staggered pump starts.
//  Also adds lead/lag rotation for even pump wear and sensor-fault detection.
//  Sits directly behind the board sensor pins inside top; drives the pump outputs.
// PARAMETERS
//  N_LEVELS   3   number of level sensors; X[0] = lowest; must be >= N_PUMPS+1
//  N_PUMPS    2   number of pumps
//  DEB_CYC    4   cycles a synced sensor word must be stable before it is accepted (>=1)
//  STAGE_CYC  8   minimum cycles between two successive changes of running count (>=1)
// PORTS
//  CLK      in   1                     system clock; all logic on rising edge
//  RST      in   1                     synchronous, active-high reset
//  X        in   N_LEVELS              raw level sensors, async, 1 = wet
//  Y        out  N_PUMPS               pump run commands, 1 = run
//  RUNNING  out  $clog2(N_PUMPS+1)     number of pumps currently commanded on (R)
//  LEAD     out  $clog2(N_PUMPS)|1     index of current lead pump
//  FAULT    out  1                     debounced sensor word not thermometer code
// BEHAVIOUR
//  Reset: Y=0, RUNNING=0, LEAD=0, FAULT=0, debounced word=0, debounce and stage counters=0.
//  Input path: 2-FF synchroniser, then debounce.
//   - Candidate word is accepted once it has matched the synced word for DEB_CYC consecutive cycles.
//   - Any change restarts the count.
//  Level L = count of ones in accepted word, valid only if the word is 0..01..1.
//  Fault:
//   - FAULT=1 in the cycle after a non-thermometer word is accepted.
//   - Forced R target = N_PUMPS (fail-safe: pump out); staging rules still apply.
//   - FAULT clears the cycle after a valid word is accepted; normal rules resume from current R.
//  Staging (one change per step, evaluated every cycle):
//   - up:   if L-1 > R and R < N_PUMPS, R <= R+1
//   - down: else if L < R, R <= R-1
//   - Net effect: pump k (1-based) starts at L >= k+1 and stops at L <= k-1 (one-sensor hysteresis).
//   - Any R change reloads the stage timer with STAGE_CYC-1.
//   - While the timer is nonzero, R holds and the timer decrements; after reset the timer is 0.
//  Rotation:
//   - Running pumps are LEAD, LEAD+1, ... (R of them, modulo N_PUMPS).
//   - Y is that mask, registered.
//   - On R transition 1->0, LEAD <= (LEAD+1) mod N_PUMPS; LEAD never changes while R > 0.
//  Latency: stable X change -> Y change = DEB_CYC+3 cycles when the stage timer is 0.
//  Simultaneous up-demand and timer expiry: change occurs in the cycle the timer reads 0.
//  RST mid-run: all pumps off the next edge; LEAD returns to 0.
//  Widths: L and R are unsigned; L-1 is computed at L's width +1 to avoid underflow at L=0.
// STRUCTURE
//  Package pump_pkg:
//   - function is_thermo(word)
//   - function popcount
//   - localparam width helpers (R_W = $clog2(N_PUMPS+1))
//  Sub-module level_debounce #(W, DEB_CYC): synchroniser plus debounce, outputs accepted word.
//  Top of block: staging FSM (R register plus stage timer), LEAD register, rotate-mask output register.
// TESTING (defaults; DEB_CYC=4, STAGE_CYC=8)
//  Ramp X 000->001->011->111 (hold 20 cyc each):
//   - Y=00, 00, then 01 at +7 cyc, then 11.
//   - RUNNING 0,0,1,2.
//  Fall X 111->011->001->000:
//   - Y stays 11 at 011, becomes 01 at 001, 00 at 000 (hysteresis).
//   - LEAD 0->1 at the last step.
//  Second fill cycle 000->011: Y=10 (pump 1 leads); drain to 000 -> LEAD=0.
//  Glitch: X=011 pulse of 3 cycles from 000 -> Y stays 00, no debounce accept.
//  Fault: X=101 held -> FAULT=1 at +6 cyc; Y=01 then 11 after 8 more cyc; X=000 -> FAULT=0, pumps step off.
//  RST asserted with Y=11 -> next edge Y=00, RUNNING=0, LEAD=0, FAULT=0.

Source files
------------

// File: rtl/pump_pkg.sv
// Shared helpers for the pump sequencer: sensor-word predicates and width helpers.
package pump_pkg;

  localparam int MAXW = 32;

  function automatic int r_width(input int n_pumps);
    return $clog2(n_pumps + 1);
  endfunction

  function automatic int lead_width(input int n_pumps);
    return (n_pumps > 1) ? $clog2(n_pumps) : 1;
  endfunction

  // 0..01..1 (including all-zero) has no carry collision with itself + 1
  function automatic logic is_thermo(input logic [MAXW-1:0] w);
    logic [MAXW:0] t;
    t = {1'b0, w} + 1'b1;
    return (({1'b0, w} & t) == '0);
  endfunction

  function automatic int unsigned popcount(input logic [MAXW-1:0] w);
    int unsigned n;
    n = 0;
    for (int i = 0; i < MAXW; i++) n += 32'(w[i]);
    return n;
  endfunction

endpackage

// File: rtl/level_debounce.sv
// Two-flop synchroniser followed by a stability debounce on the whole sensor word.
module level_debounce
  import pump_pkg::*;
#(
  parameter int W       = 3,
  parameter int DEB_CYC = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] x,
  output logic [W-1:0] word,
  output logic         fault
);

  localparam int CW = $clog2(DEB_CYC + 1);

  logic [W-1:0]  s1, s2, cand;
  logic [CW-1:0] cnt;

  // cnt counts cycles the synced word has equalled cand; saturates once accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= '0;
      s2    <= '0;
      cand  <= '0;
      cnt   <= '0;
      word  <= '0;
      fault <= 1'b0;
    end else begin
      s1 <= x;
      s2 <= s1;
      if (s2 != cand) begin
        cand <= s2;
        cnt  <= CW'(1);
        if (DEB_CYC == 1) begin
          word  <= s2;
          fault <= !is_thermo(MAXW'(s2));
        end
      end else if (cnt < CW'(DEB_CYC)) begin
        cnt <= cnt + 1'b1;
        if (cnt == CW'(DEB_CYC - 1)) begin
          word  <= cand;
          fault <= !is_thermo(MAXW'(cand));
        end
      end
    end
  end

endmodule

// File: rtl/pump_sequencer.sv
// Multi-pump sump controller: staged pump count with hysteresis, stage timer and lead/lag rotation.
module pump_sequencer
  import pump_pkg::*;
#(
  parameter int N_LEVELS  = 3,
  parameter int N_PUMPS   = 2,
  parameter int DEB_CYC   = 4,
  parameter int STAGE_CYC = 8,
  localparam int R_W  = r_width(N_PUMPS),
  localparam int LD_W = lead_width(N_PUMPS)
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [N_LEVELS-1:0] X,
  output logic [N_PUMPS-1:0]  Y,
  output logic [R_W-1:0]      RUNNING,
  output logic [LD_W-1:0]     LEAD,
  output logic                FAULT
);

  localparam int LW = $clog2(N_LEVELS + 2) + 1;
  localparam int TW = $clog2(STAGE_CYC + 1);

  logic [N_LEVELS-1:0] acc;
  logic [LW-1:0]       lvl;
  logic [R_W-1:0]      r_nx;
  logic [LD_W-1:0]     lead_nx;
  logic [N_PUMPS-1:0]  mask;
  logic [TW-1:0]       timer;

  level_debounce #(.W(N_LEVELS), .DEB_CYC(DEB_CYC)) u_deb (
    .clk  (CLK),
    .rst  (RST),
    .x    (X),
    .word (acc),
    .fault(FAULT)
  );

  // A faulty word acts as a level one above the top pump so everything stages on
  always_comb begin
    int off;
    off     = 0;
    lvl     = FAULT ? LW'(N_PUMPS + 1) : LW'(popcount(MAXW'(acc)));
    r_nx    = RUNNING;
    lead_nx = LEAD;
    mask    = '0;
    if (timer == '0) begin
      if (lvl > LW'(RUNNING) + LW'(1) && RUNNING < R_W'(N_PUMPS)) r_nx = RUNNING + 1'b1;
      else if (lvl < LW'(RUNNING))                                r_nx = RUNNING - 1'b1;
    end
    if (RUNNING == R_W'(1) && r_nx == '0)
      lead_nx = (LEAD == LD_W'(N_PUMPS - 1)) ? '0 : LEAD + 1'b1;
    for (int p = 0; p < N_PUMPS; p++) begin
      off     = (p - int'(LEAD) + N_PUMPS) % N_PUMPS;
      mask[p] = (off < int'(r_nx));
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      RUNNING <= '0;
      LEAD    <= '0;
      Y       <= '0;
      timer   <= '0;
    end else begin
      RUNNING <= r_nx;
      LEAD    <= lead_nx;
      Y       <= mask;
      if (timer != '0)          timer <= timer - 1'b1;
      else if (r_nx != RUNNING) timer <= TW'(STAGE_CYC - 1);
    end
  end

endmodule

// File: tb/tb_pump_sequencer.sv
// Scenario bench for pump_sequencer with a cycle-level behavioural model for random traffic.
module tb_pump_sequencer;
  localparam int NL = 3, NP = 2, DC = 4, SC = 8;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [NL-1:0] X   = '0;
  logic [NP-1:0] Y;
  logic [1:0]    RUNNING;
  logic [0:0]    LEAD;
  logic          FAULT;

  int pass_cnt = 0, total = 0;

  pump_sequencer #(.N_LEVELS(NL), .N_PUMPS(NP), .DEB_CYC(DC), .STAGE_CYC(SC)) dut (
    .CLK(CLK), .RST(RST), .X(X), .Y(Y), .RUNNING(RUNNING), .LEAD(LEAD), .FAULT(FAULT)
  );

  always #5 CLK = ~CLK;

  // Reference model: sensor samples age through two stages, a run-length of the aged value
  // decides acceptance, and the pump count follows the level rules from the accepted word.
  int            m_r, m_timer, m_lead, m_run, m_y;
  logic [NL-1:0] m_s1, m_s2, m_last, m_acc;
  logic          m_fault;

  always @(posedge CLK) begin : model
    int lvl;
    if (RST) begin
      m_r = 0; m_timer = 0; m_lead = 0; m_run = 0; m_y = 0;
      m_s1 = '0; m_s2 = '0; m_last = '0; m_acc = '0; m_fault = 1'b0;
    end else begin
      lvl = m_fault ? NP + 1 : $countones(m_acc);
      if (m_timer > 0) m_timer--;
      else if (lvl - 1 > m_r && m_r < NP) begin m_r++; m_timer = SC - 1; end
      else if (lvl < m_r) begin
        m_r--; m_timer = SC - 1;
        if (m_r == 0) m_lead = (m_lead + 1) % NP;
      end
      m_y = 0;
      for (int i = 0; i < m_r; i++) m_y |= 1 << ((m_lead + i) % NP);
      if (m_s2 == m_last) m_run++;
      else begin m_run = 1; m_last = m_s2; end
      if (m_run == DC) begin
        m_acc   = m_last;
        m_fault = !(m_last inside {3'b000, 3'b001, 3'b011, 3'b111});
      end
      m_s2 = m_s1;
      m_s1 = X;
    end
  end

  task automatic step(input logic [NL-1:0] x, input int n);
    X = x;
    repeat (n) @(negedge CLK);
  endtask

  task automatic test_reset;
    RST = 1'b1; X = '0;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    total++; if (Y !== 2'b00)       $display("FAIL reset_y: got %b want 00", Y);       else pass_cnt++;
    total++; if (RUNNING !== 2'd0)  $display("FAIL reset_running: got %0d want 0", RUNNING); else pass_cnt++;
    total++; if (LEAD !== 1'b0)     $display("FAIL reset_lead: got %0d want 0", LEAD);  else pass_cnt++;
    total++; if (FAULT !== 1'b0)    $display("FAIL reset_fault: got %b want 0", FAULT); else pass_cnt++;
  endtask

  task automatic test_ramp_and_fall;
    step(3'b001, 20);
    total++; if (Y !== 2'b00 || RUNNING !== 2'd0) $display("FAIL ramp_001: got Y=%b R=%0d want Y=00 R=0", Y, RUNNING); else pass_cnt++;
    step(3'b011, 6);
    total++; if (Y !== 2'b00) $display("FAIL ramp_011_pre_latency: got %b want 00", Y); else pass_cnt++;
    step(3'b011, 1);
    total++; if (Y !== 2'b01) $display("FAIL ramp_011_latency7: got %b want 01", Y); else pass_cnt++;
    step(3'b011, 13);
    total++; if (RUNNING !== 2'd1) $display("FAIL ramp_011_running: got %0d want 1", RUNNING); else pass_cnt++;
    step(3'b111, 20);
    total++; if (Y !== 2'b11 || RUNNING !== 2'd2) $display("FAIL ramp_111: got Y=%b R=%0d want Y=11 R=2", Y, RUNNING); else pass_cnt++;
    step(3'b011, 20);
    total++; if (Y !== 2'b11) $display("FAIL fall_011_hysteresis: got %b want 11", Y); else pass_cnt++;
    step(3'b001, 20);
    total++; if (Y !== 2'b01 || RUNNING !== 2'd1) $display("FAIL fall_001: got Y=%b R=%0d want Y=01 R=1", Y, RUNNING); else pass_cnt++;
    step(3'b000, 20);
    total++; if (Y !== 2'b00 || LEAD !== 1'b1) $display("FAIL fall_000: got Y=%b LEAD=%0d want Y=00 LEAD=1", Y, LEAD); else pass_cnt++;
  endtask

  task automatic test_rotation;
    step(3'b011, 20);
    total++; if (Y !== 2'b10) $display("FAIL rot_second_fill: got %b want 10", Y); else pass_cnt++;
    step(3'b000, 20);
    total++; if (Y !== 2'b00 || LEAD !== 1'b0) $display("FAIL rot_drain: got Y=%b LEAD=%0d want Y=00 LEAD=0", Y, LEAD); else pass_cnt++;
  endtask

  task automatic test_glitch;
    logic seen;
    seen = 1'b0;
    X = 3'b011;
    for (int i = 0; i < 23; i++) begin
      if (i == 3) X = 3'b000;
      @(negedge CLK);
      if (Y !== 2'b00 || RUNNING !== 2'd0) seen = 1'b1;
    end
    total++; if (seen) $display("FAIL glitch_no_accept: got pumps started want Y=00 throughout"); else pass_cnt++;
  endtask

  task automatic test_fault;
    step(3'b101, 5);
    total++; if (FAULT !== 1'b0) $display("FAIL fault_early: got %b want 0", FAULT); else pass_cnt++;
    step(3'b101, 1);
    total++; if (FAULT !== 1'b1) $display("FAIL fault_at_6: got %b want 1", FAULT); else pass_cnt++;
    step(3'b101, 1);
    total++; if (Y !== 2'b01) $display("FAIL fault_first_pump: got %b want 01", Y); else pass_cnt++;
    step(3'b101, 7);
    total++; if (Y !== 2'b01) $display("FAIL fault_stage_hold: got %b want 01", Y); else pass_cnt++;
    step(3'b101, 1);
    total++; if (Y !== 2'b11) $display("FAIL fault_second_pump: got %b want 11", Y); else pass_cnt++;
    step(3'b000, 10);
    total++; if (FAULT !== 1'b0 || Y !== 2'b01) $display("FAIL fault_clear: got F=%b Y=%b want F=0 Y=01", FAULT, Y); else pass_cnt++;
    step(3'b000, 10);
    total++; if (Y !== 2'b00 || LEAD !== 1'b1) $display("FAIL fault_drain: got Y=%b LEAD=%0d want Y=00 LEAD=1", Y, LEAD); else pass_cnt++;
  endtask

  task automatic test_mid_reset;
    step(3'b111, 40);
    total++; if (Y !== 2'b11) $display("FAIL midrst_pre: got %b want 11", Y); else pass_cnt++;
    RST = 1'b1;
    @(negedge CLK);
    total++; if (Y !== 2'b00 || RUNNING !== 2'd0 || LEAD !== 1'b0 || FAULT !== 1'b0)
      $display("FAIL midrst_state: got Y=%b R=%0d L=%0d F=%b want all 0", Y, RUNNING, LEAD, FAULT);
    else pass_cnt++;
    RST = 1'b0;
    step(3'b000, 5);
  endtask

  task automatic test_random;
    int cyc, hold, lvl, errs;
    logic [NL-1:0] w;
    cyc = 0; errs = 0;
    while (cyc < 2000) begin
      if ($urandom_range(0, 99) < 12) w = NL'($urandom_range(0, 7));
      else begin lvl = $urandom_range(0, NL); w = NL'((1 << lvl) - 1); end
      hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : $urandom_range(6, 30);
      X = w;
      for (int i = 0; i < hold; i++) begin
        @(negedge CLK);
        total++;
        if (Y !== NP'(m_y) || RUNNING !== 2'(m_r) || LEAD !== 1'(m_lead) || FAULT !== m_fault) begin
          errs++;
          if (errs <= 8)
            $display("FAIL random_cyc%0d: got Y=%b R=%0d L=%0d F=%b want Y=%b R=%0d L=%0d F=%b",
                     cyc, Y, RUNNING, LEAD, FAULT, NP'(m_y), m_r, m_lead, m_fault);
        end else pass_cnt++;
        cyc++;
      end
    end
  endtask

  initial begin
    test_reset;
    test_ramp_and_fall;
    test_rotation;
    test_glitch;
    test_fault;
    test_mid_reset;
    test_random;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
